// File: rtl/uart_tx_port_pkg.sv
// Shared definitions for the uart_tx_port UART transmitter.
// Optional feature macro: UART_TX_PARITY_EN (inserts an even-parity bit).
package uart_tx_port_pkg;

    // Bit positions inside the CPU port words
    localparam int PORT_DATA_LSB = 0;
    localparam int PORT_DATA_MSB = 7;
    localparam int PORT_REQ_BIT  = 8;
    localparam int PORT_BUSY_BIT = 0;
    localparam int PORT_ACK_BIT  = 1;

    // Transmitter states; PARITY exists only in the parity build
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } uart_tx_state_t;

    // Even parity over one data byte
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_port_baud_gen.sv
// Baud tick generator for uart_tx_port: counts 0..CLKS_PER_BIT-1 and
// flags the final cycle of each bit period.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap on terminal count, hold at zero while cleared
    always_comb begin
        bit_end = (cnt_q == TERMINAL);
        cnt_d   = cnt_q + CW'(1);
        if (clear || bit_end) begin
            cnt_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_port.sv
// UART transmitter on the sc1_cpu port words. Firmware posts a byte with a
// toggle handshake on port_out[8]; busy/ack come back on port_in[1:0].
// Optional feature macro: UART_TX_PARITY_EN (even parity, 11-bit frames).
module uart_tx_port #(
    parameter int WIDTH_REG    = 32,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH_REG-1:0] port_out,
    output logic [WIDTH_REG-1:0] port_in,
    output logic                 uart_txd
);

    import uart_tx_port_pkg::*;

    uart_tx_state_t state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic           txd_q, txd_d;
    logic           busy_q, busy_d;
    logic           ack_q, ack_d;
    logic           req_pending;
    logic           bit_end;
    logic           baud_clear;
`ifdef UART_TX_PARITY_EN
    logic           parity_q, parity_d;
`endif

    // Baud counter is held at zero in IDLE so acceptance always starts a full bit
    assign baud_clear = (state_q == IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk    (clk),
        .reset  (reset),
        .clear  (baud_clear),
        .bit_end(bit_end)
    );

    assign req_pending = (port_out[PORT_REQ_BIT] != ack_q);

    // Frame sequencing: accept in IDLE, advance one bit per baud terminal count
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        txd_d     = txd_q;
        busy_d    = busy_q;
        ack_d     = ack_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_pending) begin
                    shift_d   = port_out[PORT_DATA_MSB:PORT_DATA_LSB];
                    ack_d     = port_out[PORT_REQ_BIT];
                    busy_d    = 1'b1;
                    txd_d     = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = START;
`ifdef UART_TX_PARITY_EN
                    parity_d  = even_parity(port_out[PORT_DATA_MSB:PORT_DATA_LSB]);
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    txd_d     = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        txd_d   = parity_q;
                        state_d = PARITY;
`else
                        txd_d   = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        // Next bit is taken from the pre-shift register
                        txd_d     = shift_q[1];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    txd_d   = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                txd_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Status word back to the CPU; all other bits read as zero
    always_comb begin
        port_in                = '0;
        port_in[PORT_BUSY_BIT] = busy_q;
        port_in[PORT_ACK_BIT]  = ack_q;
    end

    assign uart_txd = txd_q;

    // Upper port_out bits carry nothing for this block
    generate
        if (WIDTH_REG > PORT_REQ_BIT + 1) begin : g_unused
            logic unused_port_bits;
            assign unused_port_bits = ^port_out[WIDTH_REG-1:PORT_REQ_BIT+1];
        end
    endgenerate

endmodule

// File: doc/uart_tx_port.md
# uart_tx_port

UART transmitter attached to the sc1_cpu general-purpose I/O word. Sits downstream of the CPU's `port_out` bus and feeds status back into its `port_in` bus. Firmware posts one byte at a time with a toggle-handshake and polls busy/ack. Serialises 8N1 frames, with optional parity, on a single TX pin.

## Interface
Parameters:
- `WIDTH_REG`, 32: width of the CPU port words; must be ≥ 9.
- `CLKS_PER_BIT`, 434: clock cycles per UART bit; must be ≥ 2. Default is 50 MHz / 115200.

Ports:
- `clk`, in, 1: system clock. This is the PLL clock used by the CPU.
- `reset`, in, 1: synchronous, active-high reset.
- `port_out`, in, `WIDTH_REG`: CPU output word.
  - [7:0]: data byte.
  - [8]: request toggle.
  - Other bits are ignored.
- `port_in`, out, `WIDTH_REG`: CPU input word.
  - [0]: busy.
  - [1]: ack toggle.
  - Other bits are 0.
- `uart_txd`, out, 1: serial output. Idle level is high.

## Operation
- State machine states: IDLE, START, DATA, PARITY (only when the macro is defined), STOP.
- **Request detection:** a request is pending when `port_out[8] != ack`.
- **Acceptance:** in IDLE with a request pending, the block does the following on one edge:
  - latches `port_out[7:0]` into the shift register;
  - sets `ack <= port_out[8]` and `busy <= 1`;
  - drives `uart_txd <= 0`;
  - enters START;
  - clears the baud counter.
- **Requests while busy:** a toggle seen while not in IDLE is not lost. It remains pending and is accepted on the first IDLE cycle.
- **Data latching:** data is sampled at acceptance, not at the toggle. Firmware must hold [7:0] until ack equals the request toggle.
- **Data-only changes:** changing [7:0] without a toggle causes no transmission.
- **Bit timing:** each bit lasts exactly `CLKS_PER_BIT` cycles. The baud counter runs 0..`CLKS_PER_BIT`-1. Its terminal count ends the current bit.
- **Data bits:** DATA sends bits LSB first. A 3-bit counter counts 0..7 and the state leaves DATA after bit 7.
- **Stop bit:** STOP drives `uart_txd` = 1. At the terminal count, the block clears `busy` and enters IDLE.
- **Outputs are registered:** `uart_txd`, `busy` and `ack` all come from flops. The block has no combinational path from `port_out` to any output.
- **Reset values:**
  - state IDLE;
  - `uart_txd` = 1;
  - `busy` = 0, `ack` = 0, so `port_in` = 0;
  - baud counter, bit counter and shift register = 0.
- **Reset mid-frame:** the frame is aborted immediately. The line returns high on the next edge. No partial bits resume after reset.
- **Counter width:** the baud counter is `$clog2(CLKS_PER_BIT)` bits wide. It never exceeds `CLKS_PER_BIT`-1.

## Timing
- **Latency:** 1 cycle from the toggle appearing on `port_out[8]` (stable before edge N) to each of these:
  - `uart_txd` low;
  - `busy` = 1;
  - `ack` updated.
  All three are visible after edge N.
- **Frame length:** 10·`CLKS_PER_BIT` cycles of low-start/data/high-stop. With parity it is 11·`CLKS_PER_BIT`.
- **Busy:** high for exactly the frame length.
- **Back-to-back frames:** a minimum of 1 IDLE cycle separates frames. With a request pending, start-to-start spacing is 10·`CLKS_PER_BIT`+1 cycles (11·`CLKS_PER_BIT`+1 with parity).
- **Reset versus request:** reset asserted on the same edge as a request wins. The request is evaluated after reset releases, against `ack` = 0.

## Configuration
- **`UART_TX_PARITY_EN` defined:**
  - The PARITY state is inserted between DATA and STOP.
  - It sends the even-parity bit, i.e. the XOR of the 8 latched data bits.
  - Frame length is 11·`CLKS_PER_BIT`.
- **Undefined:** there is no PARITY state and frames are 8N1, 10·`CLKS_PER_BIT` long.

## Structure
- **Package `uart_tx_port_pkg`:**
  - state enum `uart_tx_state_t`;
  - bit-index constants `PORT_DATA_LSB`=0, `PORT_DATA_MSB`=7, `PORT_REQ_BIT`=8, `PORT_BUSY_BIT`=0, `PORT_ACK_BIT`=1.
- **Sub-module `uart_baud_gen`:**
  - parameter `CLKS_PER_BIT`;
  - inputs `clk`, `reset`, `clear`;
  - output `bit_end`, a one-cycle pulse on terminal count.
- **Top-level wiring:** the top level connects `port_out`/`port_in` of sc1_cpu to this block and routes `uart_txd` to a pin.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 unless stated.
- **Reset:** hold reset 3 cycles with `port_out`=0 → `uart_txd`=1, `port_in`=0 throughout and after.
- **Single byte:** `port_out` = 0x155 (toggle=1, data 0x55) →
  - one cycle later: `uart_txd`=0, `port_in`=0x3;
  - line sequence, 4 cycles each: 0, 1,0,1,0,1,0,1,0, 1;
  - `busy` drops after 40 cycles; `port_in`=0x2.
- **Request while busy:** during frame 1 (0x55) set `port_out`=0x0A3 (toggle=0, data 0xA3) →
  - frame 1 completes unchanged;
  - 1 IDLE cycle follows;
  - the 0xA3 frame starts, LSB first: 1,1,0,0,0,1,0,1;
  - ack becomes 0 at its start.
- **Reset mid-frame:** assert reset during data bit 3 → next cycle `uart_txd`=1, `port_in`=0. No further low bits.
- **Data-only change:** in IDLE with `port_out[8]`=ack, change [7:0] 0x00→0xFF → `uart_txd` stays 1 and busy stays 0 for 100 cycles.
- **Parity build:** with `UART_TX_PARITY_EN` defined, send 0x07 → parity bit 1, frame 44 cycles. With 0x03 → parity bit 0.
